dsp_post_adder: RTL and testbench

Post-adder/accumulator stage of the DSP48A1 slice. Sits directly downstream of the M pipeline register. Combines the registered 36-bit product with C, PCIN, the concatenated D:A:B operand or its own P feedback under OPMODE control, then registers the 48-bit result and carry-out. Supports multiply-accumulate, cascade-add and 48-bit add/subtract.

---
 rtl/dsp48a1_pkg.sv | 46 ++++
 rtl/synch.sv | 35 +++
 rtl/dsp_post_adder.sv | 126 ++++++++++++
 tb/tb_dsp_post_adder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dsp48a1_pkg.sv
// ==== dsp48a1_pkg : shared widths, mux codes and opmode bit positions ==== rev 1.0
`default_nettype none

package dsp48a1_pkg;

   localparam int P_W  = 48;
   localparam int M_W  = 36;
   localparam int OP_W = 18;

   typedef enum logic [1:0] {
      X_ZERO = 2'd0,
      X_M    = 2'd1,
      X_P    = 2'd2,
      X_DAB  = 2'd3
   } xsel_e;

   typedef enum logic [1:0] {
      Z_ZERO = 2'd0,
      Z_PCIN = 2'd1,
      Z_P    = 2'd2,
      Z_C    = 2'd3
   } zsel_e;

   localparam int OPM_X_LSB = 0;
   localparam int OPM_Z_LSB = 2;
   localparam int OPM_CARRY = 5;
   localparam int OPM_SUB   = 7;

   // Subtraction is formed as Z + ~(X + cin) + 1 so the result is exact modulo 2^49.
   function automatic logic [P_W:0] post_add(
      input logic [P_W:0] z_ext,
      input logic [P_W:0] x_ext,
      input logic         cin,
      input logic         sub
   );
      logic [P_W:0] xc;
      xc = x_ext + {{P_W{1'b0}}, cin};
      if (sub)
         post_add = z_ext + ~xc + {{P_W{1'b0}}, 1'b1};
      else
         post_add = z_ext + xc;
   endfunction

endpackage

`default_nettype wire

// File: rtl/synch.sv
// ==== synch : generic enable/reset register, sync or async reset ==== rev 1.0
`default_nettype none

module synch #(
   parameter int    F       = 1,
   parameter string RSTTYPE = "SYNC"
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ce,
   input  logic [F-1:0] d,
   output logic [F-1:0] q
);

   generate
      if (RSTTYPE == "ASYNC") begin : g_async
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               q <= '0;
            else if (ce)
               q <= d;
         end
      end else begin : g_sync
         always_ff @(posedge clk) begin
            if (rst)
               q <= '0;
            else if (ce)
               q <= d;
         end
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/dsp_post_adder.sv
// ==== dsp_post_adder : DSP48A1 post-adder / accumulator with P, CYI and carry-out registers ==== rev 1.0
`default_nettype none

module dsp_post_adder
   import dsp48a1_pkg::*;
#(
   parameter int    PREG       = 1,
   parameter int    CARRYINREG = 1,
   parameter string CARRYINSEL = "OPMODE5"
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cep,
   input  logic            cecarryin,
   input  logic [7:0]      opmode,
   input  logic [M_W-1:0]  m,
   input  logic [OP_W-1:0] d,
   input  logic [OP_W-1:0] a,
   input  logic [OP_W-1:0] b,
   input  logic [P_W-1:0]  c,
   input  logic [P_W-1:0]  pcin,
   input  logic            carryin,
   output logic [P_W-1:0]  p,
   output logic [P_W-1:0]  pcout,
   output logic            carryout,
   output logic            carryoutf
);

   xsel_e          xsel;
   zsel_e          zsel;
   logic [P_W-1:0] p_fb;
   logic [P_W-1:0] x_mux;
   logic [P_W-1:0] z_mux;
   logic           cin_sel;
   logic           cin;
   logic [P_W:0]   sum;
   logic [P_W-1:0] p_int;
   logic           co_int;
   logic           unused_bits;

   assign unused_bits = ^{opmode[6], opmode[4], d[OP_W-1:12]};

   assign xsel = xsel_e'(opmode[OPM_X_LSB +: 2]);
   assign zsel = zsel_e'(opmode[OPM_Z_LSB +: 2]);

   always_comb begin
      x_mux = '0;
      unique case (xsel)
         X_ZERO: x_mux = '0;
         X_M:    x_mux = {{(P_W-M_W){1'b0}}, m};
         X_P:    x_mux = p_fb;
         X_DAB:  x_mux = {d[11:0], a, b};
         default: x_mux = '0;
      endcase
   end

   always_comb begin
      z_mux = '0;
      unique case (zsel)
         Z_ZERO: z_mux = '0;
         Z_PCIN: z_mux = pcin;
         Z_P:    z_mux = p_fb;
         Z_C:    z_mux = c;
         default: z_mux = '0;
      endcase
   end

   generate
      if (CARRYINSEL == "OPMODE5") begin : g_cin_opmode
         assign cin_sel = opmode[OPM_CARRY];
      end else if (CARRYINSEL == "CARRYIN") begin : g_cin_port
         assign cin_sel = carryin;
      end else begin : g_cin_zero
         assign cin_sel = 1'b0;
      end
   endgenerate

   generate
      if (CARRYINREG == 1) begin : g_cyi_reg
         synch #(.F(1), .RSTTYPE("SYNC")) u_cyi (
            .clk (clk),
            .rst (reset),
            .ce  (cecarryin),
            .d   (cin_sel),
            .q   (cin)
         );
      end else begin : g_cyi_bypass
         assign cin = cin_sel;
      end
   endgenerate

   assign sum = post_add({1'b0, z_mux}, {1'b0, x_mux}, cin, opmode[OPM_SUB]);

   // Without the P register the feedback path is tied off to avoid a combinational loop.
   generate
      if (PREG == 1) begin : g_preg
         synch #(.F(P_W), .RSTTYPE("SYNC")) u_preg (
            .clk (clk),
            .rst (reset),
            .ce  (cep),
            .d   (sum[P_W-1:0]),
            .q   (p_int)
         );
         synch #(.F(1), .RSTTYPE("SYNC")) u_coreg (
            .clk (clk),
            .rst (reset),
            .ce  (cep),
            .d   (sum[P_W]),
            .q   (co_int)
         );
         assign p_fb = p_int;
      end else begin : g_pbypass
         assign p_int  = sum[P_W-1:0];
         assign co_int = sum[P_W];
         assign p_fb   = '0;
      end
   endgenerate

   assign p         = p_int;
   assign pcout     = p_int;
   assign carryout  = co_int;
   assign carryoutf = co_int;

endmodule

`default_nettype wire

// File: tb/tb_dsp_post_adder.sv
// ==== tb_dsp_post_adder : random + directed checks of dsp_post_adder against a reference model ==== rev 1.0
`default_nettype none

module tb_dsp_post_adder;

   logic        clk;
   logic        reset;
   logic        cep;
   logic        cecarryin;
   logic [7:0]  opmode;
   logic [35:0] m;
   logic [17:0] d, a, b;
   logic [47:0] c, pcin;
   logic        carryin;

   logic [47:0] p0, pc0, p1, pc1, p2, pc2;
   logic        co0, cof0, co1, cof1, co2, cof2;

   int n_chk  = 0;
   int n_pass = 0;

   // Model state for the two registered instances (0: OPMODE5 carry, 1: CARRYIN carry)
   logic [47:0] mp  [2];
   logic        mco [2];
   logic        mcyi[2];

   dsp_post_adder u0 (
      .clk(clk), .reset(reset), .cep(cep), .cecarryin(cecarryin), .opmode(opmode),
      .m(m), .d(d), .a(a), .b(b), .c(c), .pcin(pcin), .carryin(carryin),
      .p(p0), .pcout(pc0), .carryout(co0), .carryoutf(cof0)
   );

   dsp_post_adder #(.PREG(1), .CARRYINREG(1), .CARRYINSEL("CARRYIN")) u1 (
      .clk(clk), .reset(reset), .cep(cep), .cecarryin(cecarryin), .opmode(opmode),
      .m(m), .d(d), .a(a), .b(b), .c(c), .pcin(pcin), .carryin(carryin),
      .p(p1), .pcout(pc1), .carryout(co1), .carryoutf(cof1)
   );

   dsp_post_adder #(.PREG(0), .CARRYINREG(0), .CARRYINSEL("CARRYIN")) u2 (
      .clk(clk), .reset(reset), .cep(cep), .cecarryin(cecarryin), .opmode(opmode),
      .m(m), .d(d), .a(a), .b(b), .c(c), .pcin(pcin), .carryin(carryin),
      .p(p2), .pcout(pc2), .carryout(co2), .carryoutf(cof2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached (got timeout, required finish)");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h, required %h (t=%0t)", tag, got, exp, $time);
   endtask

   // Integer view of the post-adder: operands as unsigned numbers, result modulo 2^49.
   function automatic logic [48:0] model_r(input logic [7:0] op, input logic [47:0] pfb, input logic ci);
      longint unsigned xv, zv, res;
      case (op[1:0])
         2'd0: xv = 0;
         2'd1: xv = longint'(m);
         2'd2: xv = longint'(pfb);
         default: xv = longint'({d[11:0], a, b});
      endcase
      case (op[3:2])
         2'd0: zv = 0;
         2'd1: zv = longint'(pcin);
         2'd2: zv = longint'(pfb);
         default: zv = longint'(c);
      endcase
      if (op[7])
         res = zv - (xv + longint'(ci));
      else
         res = zv + xv + longint'(ci);
      res = res % (64'd1 << 49);
      return res[48:0];
   endfunction

   task automatic step();
      logic [48:0] r;
      logic        sel;
      @(negedge clk);
      r = model_r(opmode, 48'h0, carryin);
      chk("comb_p", 64'(p2), 64'(r[47:0]));
      chk("comb_pcout", 64'(pc2), 64'(r[47:0]));
      chk("comb_co", 64'(co2), 64'(r[48]));
      chk("comb_cof", 64'(cof2), 64'(r[48]));
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         sel = (k == 0) ? opmode[5] : carryin;
         if (reset) begin
            mp[k] = '0; mco[k] = 1'b0; mcyi[k] = 1'b0;
         end else begin
            if (cep) begin
               r = model_r(opmode, mp[k], mcyi[k]);
               mp[k]  = r[47:0];
               mco[k] = r[48];
            end
            if (cecarryin) mcyi[k] = sel;
         end
      end
      #1;
      chk("op5_p", 64'(p0), 64'(mp[0]));
      chk("op5_pcout", 64'(pc0), 64'(mp[0]));
      chk("op5_co", 64'(co0), 64'(mco[0]));
      chk("op5_cof", 64'(cof0), 64'(mco[0]));
      chk("cin_p", 64'(p1), 64'(mp[1]));
      chk("cin_pcout", 64'(pc1), 64'(mp[1]));
      chk("cin_co", 64'(co1), 64'(mco[1]));
      chk("cin_cof", 64'(cof1), 64'(mco[1]));
   endtask

   task automatic randomize_operands();
      logic [63:0] t;
      m = 36'($urandom()) ^ {$urandom_range(15, 0), 32'h0};
      d = 18'($urandom()); a = 18'($urandom()); b = 18'($urandom());
      t = {$urandom(), $urandom()}; c = t[47:0];
      t = {$urandom(), $urandom()}; pcin = t[47:0];
      carryin = 1'($urandom());
   endtask

   initial begin
      reset = 1'b1; cep = 1'b1; cecarryin = 1'b1; opmode = 8'b0010_1111;
      m = 36'd77; d = 18'h3; a = 18'h5; b = 18'h9; c = 48'h1234_5678; pcin = 48'h42; carryin = 1'b1;
      for (int i = 0; i < 2; i++) step();
      chk("reset_p", 64'(p0), 64'h0);
      chk("reset_co", 64'(co0), 64'h0);

      // Multiply pass
      reset = 1'b0; cecarryin = 1'b1;
      opmode = 8'b0000_0001; m = 36'd100; carryin = 1'b0;
      step(); step();
      chk("mul_pass_p", 64'(p0), 64'd100);
      chk("mul_pass_co", 64'(co0), 64'd0);

      // Accumulate from zero, hold, then reset
      reset = 1'b1; step(); reset = 1'b0;
      opmode = 8'b0000_1001; m = 36'd5;
      for (int i = 1; i <= 4; i++) begin
         step();
         chk("acc_p", 64'(p0), 64'(5 * i));
      end
      cep = 1'b0;
      step(); step();
      chk("acc_hold_p", 64'(p0), 64'd20);
      reset = 1'b1; step();
      chk("acc_reset_p", 64'(p0), 64'd0);
      reset = 1'b0; cep = 1'b1;

      // Subtract with carry
      opmode = 8'b1010_1101; c = 48'd1000; m = 36'd10;
      step(); step();
      chk("sub_p", 64'(p0), 64'd989);
      chk("sub_co", 64'(co0), 64'd0);
      opmode = 8'b1000_1101; c = 48'd0; m = 36'd1;
      step(); step();
      chk("sub_wrap_p", 64'(p0), 64'hFFFF_FFFF_FFFF);
      chk("sub_wrap_co", 64'(co0), 64'd1);

      // Overflow add
      opmode = 8'b0000_1111; c = 48'hFFFF_FFFF_FFFF; d = 18'd0; a = 18'd0; b = 18'd1;
      step(); step();
      chk("ovf_p", 64'(p0), 64'd0);
      chk("ovf_co", 64'(co0), 64'd1);
      chk("ovf_cof", 64'(cof0), 64'd1);

      // Cascade with port carry
      opmode = 8'b0000_0100; pcin = 48'h1234; carryin = 1'b1;
      step(); step();
      chk("cascade_p", 64'(p1), 64'h1235);

      // Reset and cep together: reset wins
      reset = 1'b1; cep = 1'b1; step();
      chk("reset_wins_p", 64'(p1), 64'h0);
      reset = 1'b0;

      for (int i = 0; i < 400; i++) begin
         randomize_operands();
         opmode    = 8'($urandom());
         cep       = ($urandom_range(9, 0) < 8);
         cecarryin = ($urandom_range(9, 0) < 8);
         reset     = ($urandom_range(99, 0) < 3);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
